// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour and key types, and the box clamp helper.
// Latency: none (types and constants only); backpressure: not applicable.
package vga_pkg;

    localparam int CLK_DIV  = 4;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 29;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int BOX      = 32;
    localparam int STEP     = 8;

    localparam int H_TOTAL    = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL    = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_DE_START = H_SYNC + H_BP;
    localparam int V_DE_START = V_SYNC + V_BP;
    localparam int BOX_X_MAX  = H_ACTIVE - BOX;
    localparam int BOX_Y_MAX  = V_ACTIVE - BOX;
    localparam int BOX_X_RST  = BOX_X_MAX / 2;
    localparam int BOX_Y_RST  = BOX_Y_MAX / 2;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic center;
    } keys_t;

    // Candidate position is computed signed so a step past zero can be caught.
    function automatic logic [9:0] clamp_pos(input logic signed [10:0] v, input logic [9:0] hi);
        if (v[10])
            return '0;
        else if (v[9:0] > hi)
            return hi;
        else
            return v[9:0];
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider, h/v raster counters and combinational sync/blank/coordinate decode.
// Latency: decodes follow the counters combinationally; backpressure: none, free-running.
module vga_timing #(
    parameter int CLK_DIV  = vga_pkg::CLK_DIV,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       tick,
    output logic       frame_end,
    output logic       hs_c,
    output logic       vs_c,
    output logic       de_c,
    output logic [9:0] px,
    output logic [9:0] py
);

    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [9:0] H_S_END  = 10'(H_SYNC);
    localparam logic [9:0] V_S_END  = 10'(V_SYNC);
    localparam logic [9:0] H_DE0    = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_DE1    = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] V_DE0    = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_DE1    = 10'(V_SYNC + V_BP + V_ACTIVE);

    logic [1:0] div;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;

    assign tick = (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div   <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            div <= '0;
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end else begin
            div <= div + 2'd1;
        end
    end

    assign frame_end = tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign hs_c      = (h_cnt >= H_S_END);
    assign vs_c      = (v_cnt >= V_S_END);
    assign de_c      = (h_cnt >= H_DE0) && (h_cnt < H_DE1) && (v_cnt >= V_DE0) && (v_cnt < V_DE1);
    // Only meaningful while de_c is high; wraps harmlessly in blanking.
    assign px        = h_cnt - H_DE0;
    assign py        = v_cnt - V_DE0;

endmodule

// File: rtl/vga_frame_tx.sv
// VGA transmit engine: key-driven 4:4:4 colour box over a white-bordered field, 640x480 timing.
// Latency: outputs registered one pixel tick after the counters; backpressure: none, free-running.
module vga_frame_tx
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = vga_pkg::CLK_DIV,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int BOX      = vga_pkg::BOX,
    parameter int STEP     = vga_pkg::STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] sw,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        center,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hs,
    output logic        vs,
    output logic        de
);

    localparam logic [9:0]         X_MAX  = 10'(H_ACTIVE - BOX);
    localparam logic [9:0]         Y_MAX  = 10'(V_ACTIVE - BOX);
    localparam logic [9:0]         X_RST  = 10'((H_ACTIVE - BOX) / 2);
    localparam logic [9:0]         Y_RST  = 10'((V_ACTIVE - BOX) / 2);
    localparam logic [9:0]         X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]         Y_LAST = 10'(V_ACTIVE - 1);
    localparam logic [10:0]        BOX_W  = 11'(BOX);
    localparam logic signed [10:0] STEP_S = 11'(STEP);

    logic       tick;
    logic       frame_end;
    logic       hs_c;
    logic       vs_c;
    logic       de_c;
    logic [9:0] px;
    logic [9:0] py;

    vga_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP)
    ) u_timing (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .frame_end (frame_end),
        .hs_c      (hs_c),
        .vs_c      (vs_c),
        .de_c      (de_c),
        .px        (px),
        .py        (py)
    );

    keys_t             key_raw;
    keys_t             key_s1;
    keys_t             key_s2;
    keys_t             key_s3;
    keys_t             key_edge;
    keys_t             pend;
    logic [9:0]        box_x;
    logic [9:0]        box_y;
    rgb_t              col;
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [10:0] nx;
    logic signed [10:0] ny;

    assign key_raw  = {up, down, left, right, center};
    assign key_edge = key_s2 & ~key_s3;

    always_comb begin
        dx = '0;
        dy = '0;
        if (pend.right && !pend.left)
            dx = STEP_S;
        else if (pend.left && !pend.right)
            dx = -STEP_S;
        if (pend.down && !pend.up)
            dy = STEP_S;
        else if (pend.up && !pend.down)
            dy = -STEP_S;
        nx = $signed({1'b0, box_x}) + dx;
        ny = $signed({1'b0, box_y}) + dy;
    end

    // Box state and colour only change at the frame boundary, so each frame is uniform.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_s1 <= '0;
            key_s2 <= '0;
            key_s3 <= '0;
            pend   <= '0;
            box_x  <= X_RST;
            box_y  <= Y_RST;
            col    <= '0;
        end else begin
            key_s1 <= key_raw;
            key_s2 <= key_s1;
            key_s3 <= key_s2;
            if (frame_end) begin
                pend <= key_edge;
                col  <= sw;
                if (pend.center) begin
                    box_x <= X_RST;
                    box_y <= Y_RST;
                end else begin
                    box_x <= clamp_pos(nx, X_MAX);
                    box_y <= clamp_pos(ny, Y_MAX);
                end
            end else begin
                pend <= pend | key_edge;
            end
        end
    end

    logic hit;
    logic border;
    rgb_t pix;

    always_comb begin
        hit = (px >= box_x) && ({1'b0, px} < {1'b0, box_x} + BOX_W) &&
              (py >= box_y) && ({1'b0, py} < {1'b0, box_y} + BOX_W);
        border = (px == 10'd0) || (px == X_LAST) || (py == 10'd0) || (py == Y_LAST);
        pix = '0;
        if (de_c) begin
            if (hit)
                pix = col;
            else if (border)
                pix = 12'hFFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs    <= 1'b1;
            vs    <= 1'b1;
            de    <= 1'b0;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (tick) begin
            hs    <= hs_c;
            vs    <= vs_c;
            de    <= de_c;
            red   <= pix.r;
            green <= pix.g;
            blue  <= pix.b;
        end
    end

endmodule

// File: tb/tb_vga_frame_tx.sv
// Directed bench on a shrunken raster: pixel scoreboard plus sync/blank period measurements.
module tb_vga_frame_tx;

    localparam int CD  = 4;
    localparam int HS  = 4;
    localparam int HBP = 4;
    localparam int HA  = 32;
    localparam int HFP = 4;
    localparam int VS  = 2;
    localparam int VBP = 2;
    localparam int VA  = 20;
    localparam int VFP = 2;
    localparam int BX  = 8;
    localparam int ST  = 4;

    localparam int HT   = HS + HBP + HA + HFP;
    localparam int VT   = VS + VBP + VA + VFP;
    localparam int FP   = HT * VT;
    localparam int H0   = HS + HBP;
    localparam int V0   = VS + VBP;
    localparam int XMAX = HA - BX;
    localparam int YMAX = VA - BX;
    localparam int XC   = XMAX / 2;
    localparam int YC   = YMAX / 2;

    localparam logic [4:0] K_UP = 5'b10000;
    localparam logic [4:0] K_DN = 5'b01000;
    localparam logic [4:0] K_LF = 5'b00100;
    localparam logic [4:0] K_RT = 5'b00010;
    localparam logic [4:0] K_CT = 5'b00001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] sw = '0;
    logic        up = 1'b0;
    logic        down = 1'b0;
    logic        left = 1'b0;
    logic        right = 1'b0;
    logic        center = 1'b0;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        hs;
    logic        vs;
    logic        de;

    vga_frame_tx #(
        .CLK_DIV (CD), .H_SYNC (HS), .H_BP (HBP), .H_ACTIVE (HA), .H_FP (HFP),
        .V_SYNC (VS), .V_BP (VBP), .V_ACTIVE (VA), .V_FP (VFP), .BOX (BX), .STEP (ST)
    ) dut (
        .clk (clk), .rst_n (rst_n), .sw (sw),
        .up (up), .down (down), .left (left), .right (right), .center (center),
        .red (red), .green (green), .blue (blue), .hs (hs), .vs (vs), .de (de)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) begin
        if (!rst_n)
            edge_n <= 0;
        else
            edge_n <= edge_n + 1;
    end

    typedef struct {
        logic [63:0] tag;
        int          due;
        logic [14:0] exp;
    } sb_t;

    sb_t         sb[$];
    sb_t         cur;
    logic [14:0] obs;
    int          passed = 0;
    int          total = 0;
    int          bx;
    int          by;
    logic [11:0] col;

    // Expected {hs,vs,de,rgb} for raster position (h,v) given the box state of that frame.
    function automatic logic [14:0] model(input int h, input int v);
        logic        e_hs;
        logic        e_vs;
        logic        e_de;
        logic [11:0] c;
        int          px;
        int          py;
        e_hs = (h >= HS);
        e_vs = (v >= VS);
        e_de = (h >= H0) && (h < H0 + HA) && (v >= V0) && (v < V0 + VA);
        px = h - H0;
        py = v - V0;
        c = 12'h000;
        if (e_de) begin
            if (px >= bx && px < bx + BX && py >= by && py < by + BX)
                c = col;
            else if (px == 0 || px == HA - 1 || py == 0 || py == VA - 1)
                c = 12'hFFF;
        end
        return {e_hs, e_vs, e_de, c};
    endfunction

    task automatic push(input logic [63:0] tag, input int f, input int h, input int v);
        sb_t e;
        int  i;
        e.tag = tag;
        e.due = CD * (f * FP + v * HT + h + 1);
        e.exp = model(h, v);
        i = 0;
        while (i < sb.size() && sb[i].due <= e.due)
            i++;
        sb.insert(i, e);
    endtask

    task automatic push_frame(input int f);
        push("sync",  f, 0, 0);
        push("hsend", f, HS, 0);
        push("boxtl", f, H0 + bx, V0 + by);
        push("boxbr", f, H0 + bx + BX - 1, V0 + by + BX - 1);
        push("boxrt", f, H0 + bx + BX, V0 + by);
        push("boxlf", f, H0 + bx - 1, V0 + by);
        push("boxab", f, H0 + bx, V0 + by - 1);
        push("bordl", f, H0, V0 + 10);
        push("bordr", f, H0 + HA - 1, V0 + by);
        push("bordt", f, H0 + 5, V0);
        push("bordb", f, H0 + 5, V0 + VA - 1);
        push("inner", f, H0 + 1, V0 + 1);
        push("porch", f, H0 + HA, V0 + 10);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].due <= edge_n) begin
                cur = sb.pop_front();
                obs = {hs, vs, de, red, green, blue};
                total++;
                assert (cur.due == edge_n && obs === cur.exp) passed++;
                else $error("FAIL %s edge=%0d due=%0d got hs_vs_de_rgb=%h required=%h",
                            cur.tag, edge_n, cur.due, obs, cur.exp);
            end
        end
    end

    int   hs_fall = -1, hs_per = 0, hs_low = 0;
    int   vs_fall = -1, vs_per = 0, vs_low = 0;
    int   de_rise = 0, de_run = 0, de_lines = 0, de_clks = 0, de_lines_f = 0, de_clks_f = 0;
    logic hs_q = 1'b1, vs_q = 1'b1, de_q = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            de_q     <= 1'b0;
            hs_fall  <= -1;
            vs_fall  <= -1;
            de_lines <= 0;
            de_clks  <= 0;
        end else begin
            if (hs_q && !hs) begin
                if (hs_fall >= 0)
                    hs_per <= edge_n - hs_fall;
                hs_fall <= edge_n;
            end
            if (!hs_q && hs)
                hs_low <= edge_n - hs_fall;
            if (!de_q && de) begin
                de_rise  <= edge_n;
                de_lines <= de_lines + 1;
            end
            if (de_q && !de)
                de_run <= edge_n - de_rise;
            if (de)
                de_clks <= de_clks + 1;
            if (vs_q && !vs) begin
                if (vs_fall >= 0) begin
                    vs_per     <= edge_n - vs_fall;
                    de_lines_f <= de_lines;
                    de_clks_f  <= de_clks;
                end
                vs_fall  <= edge_n;
                de_lines <= 0;
                de_clks  <= 0;
            end
            if (!vs_q && vs)
                vs_low <= edge_n - vs_fall;
            hs_q <= hs;
            vs_q <= vs;
            de_q <= de;
        end
    end

    task automatic chk(input logic [63:0] tag, input int got, input int exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0d required=%0d", tag, got, exp);
    endtask

    task automatic wait_edge(input int n);
        int g;
        g = 0;
        while (edge_n < n && g < 200000) begin
            @(negedge clk);
            g++;
        end
        if (edge_n < n)
            chk("timeout", edge_n, n);
    endtask

    task automatic press(input logic [4:0] k, input int clks);
        {up, down, left, right, center} = k;
        repeat (clks) @(negedge clk);
        {up, down, left, right, center} = 5'b0;
    endtask

    function automatic int line_edge(input int f, input int line);
        return CD * (f * FP + line * HT);
    endfunction

    initial begin
        rst_n = 1'b0;
        sw    = 12'hFFF;
        repeat (3) @(negedge clk);
        chk("rst_hs",  int'(hs), 1);
        chk("rst_vs",  int'(vs), 1);
        chk("rst_de",  int'(de), 0);
        chk("rst_rgb", int'({red, green, blue}), 0);

        rst_n = 1'b1;
        bx = XC; by = YC; col = 12'h000;
        push_frame(0);
        col = 12'hFFF;
        push_frame(1);

        wait_edge(line_edge(1, 12));
        chk("hs_per",  hs_per, HT * CD);
        chk("hs_low",  hs_low, HS * CD);
        chk("vs_per",  vs_per, FP * CD);
        chk("vs_low",  vs_low, VS * HT * CD);
        chk("de_run",  de_run, HA * CD);
        chk("de_line", de_lines_f, VA);
        chk("de_clks", de_clks_f, VA * HA * CD);

        // Frame 1: up press and a new colour, both visible from frame 2.
        sw = 12'h5A3;
        press(K_UP, 100);
        by = by - ST;
        col = 12'h5A3;
        push_frame(2);

        // Frame 2: opposing keys cancel.
        wait_edge(line_edge(2, 10));
        press(K_LF | K_RT, 20);
        push_frame(3);

        // Frame 3: up past the top edge saturates at 0.
        wait_edge(line_edge(3, 10));
        press(K_UP, 4);
        by = 0;
        push_frame(4);

        // Frames 4..7: right presses walk the box into the right border and saturate.
        for (int f = 4; f < 8; f++) begin
            wait_edge(line_edge(f, 10));
            press(K_RT, 4);
            bx = (bx + ST > XMAX) ? XMAX : bx + ST;
            push_frame(f + 1);
        end

        // Frame 8: center overrides the other keys.
        wait_edge(line_edge(8, 10));
        press(K_CT | K_UP | K_LF, 6);
        bx = XC; by = YC;
        push_frame(9);

        wait_edge(line_edge(9, 10));
        press(K_RT | K_DN, 6);
        bx = XC + ST; by = YC + ST;
        push_frame(10);

        // Frame 10: one-clock reset inside the box during active video.
        wait_edge(CD * (10 * FP + (V0 + 10) * HT + H0 + 20 + 1));
        chk("pre_de",  int'(de), 1);
        chk("pre_rgb", int'({red, green, blue}), 12'h5A3);
        sb.delete();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_hs",  int'(hs), 1);
        chk("mrst_vs",  int'(vs), 1);
        chk("mrst_de",  int'(de), 0);
        chk("mrst_rgb", int'({red, green, blue}), 0);
        rst_n = 1'b1;
        bx = XC; by = YC; col = 12'h000;
        push_frame(0);
        col = 12'h5A3;
        push_frame(1);

        wait_edge(CD * 2 * FP + 2 * CD);
        chk("sb_left", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vga_frame_tx.md
# vga_frame_tx

Transmit-side VGA engine: derives the 25 MHz pixel cadence from the 100 MHz system clock, generates 640x480 sync/blanking timing (800x521 frame), and drives 4:4:4 RGB for a key-movable 32x32 colour box over a white-bordered black field. Sits between the board buttons/switches and the VGA connector. Timing is bit-compatible with the team's frame-capture bench: back porch 48 px / 29 lines, active-low syncs.

## Interface
Parameters:
- CLK_DIV, 4: system clocks per pixel.
- H_SYNC, 96 / H_BP, 48 / H_ACTIVE, 640 / H_FP, 16: horizontal timing, in pixels.
- V_SYNC, 2 / V_BP, 29 / V_ACTIVE, 480 / V_FP, 10: vertical timing, in lines.
- BOX, 32: box side, in pixels.
- STEP, 8: box move per key press, in pixels.

Ports:
- clk  in  1  system clock, 100 MHz; one clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- sw  in  12  box colour {R,G,B}, 4 bits each.
- up, down, left, right, center  in  1 each  asynchronous button inputs, active-high.
- red, green, blue  out  4 each  pixel colour, registered.
- hs, vs  out  1 each  syncs, active-low, registered.
- de  out  1  active-video flag, registered.

## Operation
- Pixel tick: 2-bit divider counts 0..CLK_DIV-1; tick = (div == CLK_DIV-1). Counters and outputs update only on a tick.
- h_cnt runs 0..799 and wraps. v_cnt advances when h_cnt wraps, runs 0..520 and wraps.
- hs = 0 while h_cnt < 96. vs = 0 while v_cnt < 2.
- de = 1 while h_cnt is in [144,784) and v_cnt is in [31,511).
- Active coordinates: px = h_cnt-144, py = v_cnt-31.
- Colour priority when de = 1:
  - Box hit (px in [box_x, box_x+32), py in [box_y, box_y+32)) gives the latched sw colour.
  - Otherwise, border (px = 0, px = 639, py = 0 or py = 479) gives 12'hFFF.
  - Otherwise 12'h000.
- When de = 0, RGB = 0.
- Keys:
  - 2-flop synchroniser per key, then rising-edge detect.
  - Each edge sets a sticky pending bit.
- Frame boundary is the tick where h_cnt = 799 and v_cnt = 520. On that tick:
  - sw is latched.
  - center pending puts the box at (304,224); it overrides all other keys.
  - Otherwise, x moves by STEP×(right-left) and y by STEP×(down-up). Opposing keys cancel.
  - Results saturate to x in [0,608] and y in [0,448]. Compute in 11-bit signed, then clamp.
  - All pending bits clear. An edge arriving on the boundary tick itself is kept for the next frame.
- Colour and position are therefore constant across a whole frame.

## Timing
- Reset (rst_n = 0 at a clk edge): div, h_cnt and v_cnt = 0; hs = 1, vs = 1, de = 0, RGB = 0; box at (304,224); latched colour 0; pending bits cleared. Reset mid-frame restarts the frame cleanly on the next clock.
- Outputs lag the counters by one pixel tick. The registers load from the current counter values, so hs falls on the first tick after reset.
- Line = 3200 clk. Frame = 1,667,200 clk (16.672 ms).
- hs low for 384 clk. vs low for 2 lines (6400 clk).
- A key press must be at least 2 clk wide to be seen. It takes effect on the first frame boundary after the edge clears the synchroniser (2 clk).

## Structure
- vga_pkg holds the timing constants and derived values: H_TOTAL=800, V_TOTAL=521, H_DE_START=144, V_DE_START=31, BOX_X_MAX=608, BOX_Y_MAX=448, reset box position.
- Sub-module vga_timing: divider, h/v counters, hs/vs/de, px/py, tick and frame_end strobes.
- The top level holds key synchronisation, box state, colour mux and output registers.

## Test plan
- Reset release, sw = 0: hs period 3200 clk, low 384; vs period 1,667,200 clk, low 6400; de high 2560 clk/line for 480 lines/frame.
- Frame 0, sw = 12'hFFF: border pixels FFF, interior 000. Box region (304..335, 224..255) stays 000 because the colour latches only at the first boundary; frame 1 box = FFF.
- up pulse 1000 ns mid-frame: box_y = 224 in the current frame, 216 in the next. left+right pressed in the same frame: box_x unchanged.
- 40 right presses across 40 frames: box_x saturates at 608, never wraps; box right edge at px 639.
- center plus up in the same frame with box at (0,0): next frame box at (304,224).
- rst_n low for 1 clk in the middle of active video: next clock hs = vs = 1, de = 0, RGB = 0; box back at (304,224); first tick after release starts a new frame.
